// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave with runtime-selected mode, a 1-entry TX holding register and a
// registered RX word with valid/ready handshake. All pin inputs pass through 2-flop synchronisers.
module spi_slave_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    LSB_FIRST  = 1'b0,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  ss,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  frame_abort
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    // Synchronisers and edge history
    logic ss_m_q, ss_m_d, ss_s_q, ss_s_d;
    logic sck_m_q, sck_m_d, sck_s_q, sck_s_d, sck_prev_q, sck_prev_d;
    logic mosi_m_q, mosi_m_d, mosi_s_q, mosi_s_d;
    // Becomes 1 once both ss synchroniser flops hold real pin samples after reset
    logic [1:0] sync_fill_q, sync_fill_d;
    // A frame already running when reset released must not be picked up mid-way
    logic armed_q, armed_d;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  load_pend_q, load_pend_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  busy_q, busy_d;
    logic                  rx_overrun_q, rx_overrun_d;
    logic                  tx_underrun_q, tx_underrun_d;
    logic                  frame_abort_q, frame_abort_d;

    logic cpol, cpha, sck_rise, sck_fall, lead, trail, selected;
    logic sample, shift, drive, ss_fall, ss_rise, word_done, load;
    logic [DATA_WIDTH-1:0] rx_asm;

    // Bit that goes out next from the transmit shift register
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] sr);
        return LSB_FIRST ? sr[0] : sr[DATA_WIDTH-1];
    endfunction

    // Transmit shift register after one bit has been driven out
    function automatic logic [DATA_WIDTH-1:0] shifted(input logic [DATA_WIDTH-1:0] sr);
        return LSB_FIRST ? (sr >> 1) : (sr << 1);
    endfunction

    // Next-state computation for synchronisers, frame state, TX/RX datapath and status pulses
    always_comb begin
        ss_m_d        = ss;
        ss_s_d        = ss_m_q;
        sck_m_d       = sck;
        sck_s_d       = sck_m_q;
        sck_prev_d    = sck_s_q;
        mosi_m_d      = mosi;
        mosi_s_d      = mosi_m_q;
        sync_fill_d   = {sync_fill_q[0], 1'b1};
        armed_d       = armed_q | (sync_fill_q[1] & ss_s_q);
        state_d       = state_q;
        mode_d        = ss_s_q ? mode : mode_q;
        bit_cnt_d     = bit_cnt_q;
        rx_sr_d       = rx_sr_q;
        tx_sr_d       = tx_sr_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        load_pend_d   = 1'b0;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;

        cpol     = mode_q[1];
        cpha     = mode_q[0];
        sck_rise = sck_s_q & ~sck_prev_q;
        sck_fall = ~sck_s_q & sck_prev_q;
        lead     = cpol ? sck_fall : sck_rise;
        trail    = cpol ? sck_rise : sck_fall;
        selected = (state_q == ST_ACTIVE) && !ss_s_q;
        sample   = selected && (cpha ? trail : lead);
        // With CPHA=0 the trailing edge right after a word completes must not consume a bit:
        // the first bit of the freshly loaded word was already driven the cycle after the load.
        shift    = selected && (cpha ? lead : (trail && (bit_cnt_q != '0)));
        drive    = shift || load_pend_q;
        ss_fall  = (state_q == ST_IDLE) && !ss_s_q && armed_q;
        ss_rise  = (state_q == ST_ACTIVE) && ss_s_q;
        word_done = sample && (bit_cnt_q == LAST_BIT);
        load     = ss_fall || word_done;
        rx_asm   = LSB_FIRST ? {mosi_s_q, rx_sr_q[DATA_WIDTH-1:1]}
                             : {rx_sr_q[DATA_WIDTH-2:0], mosi_s_q};

        if (sample) begin
            rx_sr_d   = rx_asm;
            bit_cnt_d = word_done ? '0 : bit_cnt_q + CW'(1);
        end

        if (rx_valid_q && rx_ready)
            rx_valid_d = 1'b0;
        if (word_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_asm;
                rx_valid_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end

        if (drive) begin
            miso_d  = first_bit(tx_sr_q);
            tx_sr_d = shifted(tx_sr_q);
        end

        if (load) begin
            load_pend_d = ~cpha;
            if (hold_full_q) begin
                tx_sr_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_sr_d       = TX_IDLE;
                tx_underrun_d = 1'b1;
            end
        end

        // The hold only accepts when empty, so a write never races a load that drains it
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (ss_fall) begin
            state_d   = ST_ACTIVE;
            bit_cnt_d = '0;
        end else if (ss_rise) begin
            state_d       = ST_IDLE;
            frame_abort_d = (bit_cnt_q != '0);
            bit_cnt_d     = '0;
        end

        miso_oe_d = (state_d == ST_ACTIVE);
        busy_d    = (state_d == ST_ACTIVE) && (bit_cnt_d != '0);
    end

    // State registers; everything returns to idle values on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_m_q        <= 1'b1;
            ss_s_q        <= 1'b1;
            sck_m_q       <= 1'b0;
            sck_s_q       <= 1'b0;
            sck_prev_q    <= 1'b0;
            mosi_m_q      <= 1'b0;
            mosi_s_q      <= 1'b0;
            sync_fill_q   <= 2'b00;
            armed_q       <= 1'b0;
            state_q       <= ST_IDLE;
            mode_q        <= 2'b00;
            bit_cnt_q     <= '0;
            rx_sr_q       <= '0;
            tx_sr_q       <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            load_pend_q   <= 1'b0;
            miso_q        <= 1'b1;
            miso_oe_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            ss_m_q        <= ss_m_d;
            ss_s_q        <= ss_s_d;
            sck_m_q       <= sck_m_d;
            sck_s_q       <= sck_s_d;
            sck_prev_q    <= sck_prev_d;
            mosi_m_q      <= mosi_m_d;
            mosi_s_q      <= mosi_s_d;
            sync_fill_q   <= sync_fill_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            mode_q        <= mode_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_sr_q       <= rx_sr_d;
            tx_sr_q       <= tx_sr_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            load_pend_q   <= load_pend_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            busy_q        <= busy_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = busy_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: an 8-bit MSB-first instance and a 16-bit LSB-first instance sharing
// sck/mosi/mode, each with its own slave select. A behavioural SPI master drives the pins.
module tb_spi_slave_ctrl;

    localparam int H = 6;   // SCK half period in clk cycles

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        ss8 = 1'b1, ss16 = 1'b1, sck = 1'b0, mosi = 1'b0;

    logic        miso8, miso_oe8, tx_ready8, rx_valid8, busy8, ovr8, unr8, abt8;
    logic [7:0]  rx_data8;
    logic [7:0]  tx_data8 = 8'h00;
    logic        tx_valid8 = 1'b0, rx_ready8 = 1'b1;

    logic        miso16, miso_oe16, tx_ready16, rx_valid16, busy16, ovr16, unr16, abt16;
    logic [15:0] rx_data16;
    logic [15:0] tx_data16 = 16'h0000;
    logic        tx_valid16 = 1'b0, rx_ready16 = 1'b0;

    spi_slave_ctrl #(.DATA_WIDTH(8), .LSB_FIRST(1'b0), .TX_IDLE(8'hFF)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ss(ss8), .sck(sck), .mosi(mosi),
        .miso(miso8), .miso_oe(miso_oe8), .tx_data(tx_data8), .tx_valid(tx_valid8),
        .tx_ready(tx_ready8), .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_ready(rx_ready8),
        .busy(busy8), .rx_overrun(ovr8), .tx_underrun(unr8), .frame_abort(abt8));

    spi_slave_ctrl #(.DATA_WIDTH(16), .LSB_FIRST(1'b1), .TX_IDLE(16'hFFFF)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ss(ss16), .sck(sck), .mosi(mosi),
        .miso(miso16), .miso_oe(miso_oe16), .tx_data(tx_data16), .tx_valid(tx_valid16),
        .tx_ready(tx_ready16), .rx_data(rx_data16), .rx_valid(rx_valid16), .rx_ready(rx_ready16),
        .busy(busy16), .rx_overrun(ovr16), .tx_underrun(unr16), .frame_abort(abt16));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: logs accepted RX words and counts status pulses
    logic [7:0] rx_log [512];
    int rx_wr = 0;
    int ovr_cnt = 0, unr_cnt = 0, abt_cnt = 0, unr16_cnt = 0, ovr16_cnt = 0, abt16_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid8 && rx_ready8) begin
                rx_log[rx_wr % 512] = rx_data8;
                rx_wr++;
            end
            if (ovr8)  ovr_cnt++;
            if (unr8)  unr_cnt++;
            if (abt8)  abt_cnt++;
            if (unr16) unr16_cnt++;
            if (ovr16) ovr16_cnt++;
            if (abt16) abt16_cnt++;
        end
    end

    // TX feeder: presents queued words on the 8-bit TX stream, one handshake at a time
    logic [7:0] tx_list [256];
    int tx_wr = 0;
    int tx_rd = 0;
    int hs_cnt = 0;
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = tx_valid8 && tx_ready8 && rst_n;
            @(posedge clk);
            #1;
            if (hs) begin
                tx_valid8 = 1'b0;
                hs_cnt++;
            end
            if (!tx_valid8 && tx_rd < tx_wr) begin
                tx_data8  = tx_list[tx_rd % 256];
                tx_rd++;
                tx_valid8 = 1'b1;
            end
        end
    end

    // SPI master
    logic [15:0] mst_out [4];
    logic [15:0] mst_in  [4];
    int   unr_at_start;
    logic last_busy;

    task automatic spi_frame(input bit sel16, input logic [1:0] md, input int w, input bit lsb,
                             input int nw, input int stop_bits);
        int cnt;
        int idx;
        logic rb;
        cnt  = 0;
        mode = md;
        sck  = md[1];
        mosi = 1'b0;
        clks(4);
        if (sel16) ss16 = 1'b0; else ss8 = 1'b0;
        clks(8);
        unr_at_start = unr_cnt;
        for (int wd = 0; wd < nw; wd++) begin
            mst_in[wd] = '0;
            for (int i = 0; i < w; i++) begin
                if (stop_bits == 0 || cnt < stop_bits) begin
                    idx = lsb ? i : w - 1 - i;
                    if (!md[0]) begin
                        mosi = mst_out[wd][idx];
                        clks(H);
                        rb  = sel16 ? miso16 : miso8;
                        sck = ~md[1];
                        clks(H);
                        sck = md[1];
                    end else begin
                        sck  = ~md[1];
                        mosi = mst_out[wd][idx];
                        clks(H);
                        rb  = sel16 ? miso16 : miso8;
                        sck = md[1];
                        clks(H);
                    end
                    mst_in[wd][idx] = rb;
                    cnt++;
                end
            end
        end
        clks(6);
        last_busy = sel16 ? busy16 : busy8;
        ss8  = 1'b1;
        ss16 = 1'b1;
        clks(8);
    endtask

    typedef struct {
        logic [1:0]      md;
        int              nw;
        int              ntx;
        logic [2:0][7:0] tx;
        logic [2:0][7:0] mo;
        logic [2:0][7:0] exp_mi;
        logic [2:0][7:0] exp_rx;
        int              exp_hs;
        int              exp_unr;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] md, input int nw, input int ntx,
                                input logic [23:0] tx, input logic [23:0] mo,
                                input logic [23:0] emi, input logic [23:0] erx,
                                input int ehs, input int eunr);
        vec_t v;
        v.md = md; v.nw = nw; v.ntx = ntx; v.tx = tx; v.mo = mo;
        v.exp_mi = emi; v.exp_rx = erx; v.exp_hs = ehs; v.exp_unr = eunr;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int rx0, hs0, unr0, ovr0, abt0;
        rx0 = rx_wr; hs0 = hs_cnt; unr0 = unr_cnt; ovr0 = ovr_cnt; abt0 = abt_cnt;
        for (int k = 0; k < v.ntx; k++) begin
            tx_list[tx_wr % 256] = v.tx[k];
            tx_wr++;
        end
        clks(6);
        for (int k = 0; k < 3; k++) mst_out[k] = {8'h00, v.mo[k]};
        spi_frame(1'b0, v.md, 8, 1'b0, v.nw, 0);
        clks(4);
        chk({tag, " underrun_at_ss_fall"}, unr_at_start - unr0, (v.ntx == 0) ? 1 : 0);
        for (int k = 0; k < v.nw; k++) begin
            chk($sformatf("%s miso_word%0d", tag, k), mst_in[k], {8'h00, v.exp_mi[k]});
            chk($sformatf("%s rx_word%0d", tag, k), rx_log[(rx0 + k) % 512], v.exp_rx[k]);
        end
        chk({tag, " rx_count"}, rx_wr - rx0, v.nw);
        chk({tag, " tx_handshakes"}, hs_cnt - hs0, v.exp_hs);
        chk({tag, " underruns"}, unr_cnt - unr0, v.exp_unr);
        chk({tag, " overruns"}, ovr_cnt - ovr0, 0);
        chk({tag, " aborts"}, abt_cnt - abt0, 0);
        chk({tag, " busy_at_end"}, last_busy, 0);
    endtask

    initial begin
        vec_t tbl [5];
        vec_t v;
        int rx0, ovr0, abt0, unr0;

        tbl[0] = mk(2'd0, 1, 2, 24'h0000A5, 24'h00003C, 24'h0000A5, 24'h00003C, 2, 0);
        tbl[1] = mk(2'd1, 3, 3, 24'h332211, 24'h665544, 24'h332211, 24'h665544, 3, 1);
        tbl[2] = mk(2'd2, 3, 3, 24'h332211, 24'h665544, 24'h332211, 24'h665544, 3, 1);
        tbl[3] = mk(2'd3, 3, 3, 24'h332211, 24'h665544, 24'h332211, 24'h665544, 3, 1);
        tbl[4] = mk(2'd0, 1, 0, 24'h000000, 24'h00005A, 24'h0000FF, 24'h00005A, 0, 2);

        // Reset state
        clks(3);
        chk("rst miso", miso8, 1);
        chk("rst miso_oe", miso_oe8, 0);
        chk("rst tx_ready", tx_ready8, 1);
        chk("rst rx_valid", rx_valid8, 0);
        chk("rst rx_data", rx_data8, 0);
        chk("rst busy", busy8, 0);
        chk("rst pulses", {ovr8, unr8, abt8}, 0);
        chk("rst miso_oe16", miso_oe16, 0);
        rst_n = 1'b1;
        clks(4);

        // Table-driven frames
        for (int t = 0; t < 5; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

        // Random frames against the word-level model: each word carries the next queued TX
        // word, or TX_IDLE once the queue runs dry; every load beyond the supply underruns.
        for (int r = 0; r < 10; r++) begin
            v.md  = 2'($urandom_range(0, 3));
            v.nw  = $urandom_range(1, 3);
            v.ntx = $urandom_range(0, v.nw);
            for (int k = 0; k < 3; k++) begin
                v.tx[k]     = 8'($urandom);
                v.mo[k]     = 8'($urandom);
                v.exp_mi[k] = (k < v.ntx) ? v.tx[k] : 8'hFF;
                v.exp_rx[k] = v.mo[k];
            end
            v.exp_hs  = v.ntx;
            v.exp_unr = v.nw + 1 - v.ntx;
            run_vec(v, $sformatf("rnd%0d", r));
        end

        // Overrun: consumer stalls across two words
        rx_ready8 = 1'b0;
        rx0 = rx_wr; ovr0 = ovr_cnt;
        mst_out[0] = 16'h0001; mst_out[1] = 16'h0002;
        spi_frame(1'b0, 2'd0, 8, 1'b0, 2, 0);
        chk("ovr rx_valid", rx_valid8, 1);
        chk("ovr rx_data_kept", rx_data8, 8'h01);
        chk("ovr pulses", ovr_cnt - ovr0, 1);
        rx_ready8 = 1'b1;
        clks(2);
        chk("ovr drained", rx_valid8, 0);
        chk("ovr drained_count", rx_wr - rx0, 1);
        chk("ovr drained_word", rx_log[rx0 % 512], 8'h01);

        // Abort after 5 bits, then a clean frame
        rx0 = rx_wr; abt0 = abt_cnt;
        mst_out[0] = 16'h00A3;
        spi_frame(1'b0, 2'd0, 8, 1'b0, 1, 5);
        chk("abort busy_mid_word", last_busy, 1);
        clks(2);
        chk("abort pulses", abt_cnt - abt0, 1);
        chk("abort no_rx", rx_wr - rx0, 0);
        chk("abort rx_valid", rx_valid8, 0);
        mst_out[0] = 16'h0077;
        spi_frame(1'b0, 2'd0, 8, 1'b0, 1, 0);
        clks(2);
        chk("after_abort rx_count", rx_wr - rx0, 1);
        chk("after_abort rx_word", rx_log[rx0 % 512], 8'h77);
        chk("after_abort pulses", abt_cnt - abt0, 1);

        // Reset mid-word: hold full at the time of reset, frame keeps running on the pins
        rx0 = rx_wr; abt0 = abt_cnt;
        mst_out[0] = 16'h00C3;
        fork
            spi_frame(1'b0, 2'd0, 8, 1'b0, 1, 0);
            begin
                clks(20);
                tx_list[tx_wr % 256] = 8'h5E;
                tx_wr++;
                clks(10);
                chk("mid_rst hold_full", tx_ready8, 0);
                #2;
                rst_n = 1'b0;
                #1;
                chk("mid_rst miso", miso8, 1);
                chk("mid_rst miso_oe", miso_oe8, 0);
                chk("mid_rst tx_ready", tx_ready8, 1);
                chk("mid_rst busy", busy8, 0);
                chk("mid_rst rx_valid", rx_valid8, 0);
                clks(3);
                rst_n = 1'b1;
                clks(6);
                chk("mid_rst still_deselected", miso_oe8, 0);
            end
        join
        clks(2);
        chk("mid_rst no_abort", abt_cnt - abt0, 0);
        chk("mid_rst no_rx", rx_wr - rx0, 0);
        unr0 = unr_cnt;
        mst_out[0] = 16'h0096;
        spi_frame(1'b0, 2'd0, 8, 1'b0, 1, 0);
        clks(2);
        chk("post_rst miso_idle", mst_in[0], 16'h00FF);
        chk("post_rst rx_count", rx_wr - rx0, 1);
        chk("post_rst rx_word", rx_log[rx0 % 512], 8'h96);
        chk("post_rst underruns", unr_cnt - unr0, 2);

        // 16-bit LSB-first instance
        tx_data16  = 16'h8001;
        tx_valid16 = 1'b1;
        clks(1);
        tx_valid16 = 1'b0;
        clks(1);
        chk("w16 hold_full", tx_ready16, 0);
        mst_out[0] = 16'h1234;
        spi_frame(1'b1, 2'd0, 16, 1'b1, 1, 0);
        clks(2);
        chk("w16 first_miso_bit", mst_in[0][0], 1);
        chk("w16 last_miso_bit", mst_in[0][15], 1);
        chk("w16 miso_word", mst_in[0], 16'h8001);
        chk("w16 rx_valid", rx_valid16, 1);
        chk("w16 rx_data", rx_data16, 16'h1234);
        chk("w16 busy", busy16, 0);
        chk("w16 miso_oe", miso_oe16, 0);
        chk("w16 underruns", unr16_cnt, 1);
        chk("w16 other_pulses", ovr16_cnt + abt16_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
